booth_dadda_mul_pipe: RTL
=========================

# booth_dadda_mul_pipe

Parametrised, pipelined radix-4 Booth multiplier with a generic Dadda reduction tree and a final two-operand adder. Each transaction is selectable signed or unsigned. The block has valid/ready handshakes on both sides, full backpressure, and a sideband tag. It replaces the fixed-width combinational Booth/Dadda datapath in the arithmetic units and sits between the operand-issue logic and the result writeback.

## Interface
- `W`, default 16: operand width; must be even and ≥ 4.
- `TAG_W`, default 4: width of the sideband tag carried with each operation.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operand pair presented.
- `in_ready`  out  1: block accepts the operand pair this cycle.
- `in_a`, `in_b`  in  W each: multiplicand and multiplier.
- `in_signed`  in  1: 1 = two's-complement operands; 0 = unsigned operands.
- `in_tag`  in  TAG_W: opaque, returned unchanged with the result.
- `out_valid`  out  1: result presented.
- `out_ready`  in  1: consumer accepts the result.
- `out_product`  out  2W: exact product.
- `out_tag`  out  TAG_W: tag of the operation whose result is presented.

## Operation
- **Operand extension.** Operands are extended to W+2 bits: sign-extended if `in_signed`, zero-extended otherwise. This gives NPP = (W+2)/2 Booth digits.
- **Booth recoding.**
  - Digit d_k is formed from b[2k+1:2k-1], with b[-1]=0, and takes a value in {0, +1, +2, −1, −2}.
  - Each partial product is the (W+3)-bit value of d_k·a.
  - Sign handling uses the standard sign-extension-prevention constant: inverted sign bit, plus the leading-1 pattern on the first row. Negation uses the one's complement, with the +1 injected in the row-below slot at column 2k.
- **Stage 1 (S1).** Registers the NPP partial-product rows, the sign/negate bits, and the tag.
- **Stage 2 (S2).**
  - Dadda reduction of the S1 matrix to two rows, using full and half adders only.
  - The reduction uses the height sequence 2, 3, 4, 6, 9, 13, … up to NPP+1.
  - Registers the two rows and the tag.
- **Stage 3 (S3).** Two-operand adder on the S2 rows. Bits ≥ 2W are discarded; the result is registered into `out_product` and `out_tag`.
- **Result requirement.** `out_product` equals a·b interpreted in the selected mode, exactly, over the low 2W bits. This holds for every operand pair, including the most negative signed values and all-ones unsigned values.

## Timing
- **Latency.** Exactly 3 cycles from the accepting edge (`in_valid & in_ready`) to `out_valid` when there is no backpressure. Throughput is 1 operation per cycle.
- **Per-stage valid flags.** Stages carry flags v1, v2, v3, with v3 = `out_valid`.
- **Stage advance rule.**
  - rdy3 = ~v3 | out_ready.
  - rdy2 = ~v2 | rdy3.
  - rdy1 = ~v1 | rdy2.
  - `in_ready` = rdy1.
  - A stage's data registers load only when that stage advances. Bubbles collapse, so a stalled pipeline still accepts input until every stage holds a valid entry.
- **Combinational path.** `in_ready` depends combinationally on `out_ready`; this path is required.
- **Output stability.** While `out_valid & ~out_ready`, `out_product` and `out_tag` hold stable. `in_*` are ignored when `in_valid` is 0 or `in_ready` is 0.
- **Simultaneous events.** With a full pipeline and `out_ready`=1, a new input is accepted in the same cycle as the oldest result retires; no bubble is inserted.
- **Reset.**
  - Values after reset: v1=v2=v3=0, `out_valid`=0, `out_product`=0, `out_tag`=0, `in_ready`=1 in the cycle after reset.
  - Reset mid-operation discards all in-flight entries; no result is ever emitted for them.
  - Inputs presented while `rst`=1 are not accepted.
- **Ordering.** Results emerge strictly in acceptance order.

## Structure
- **Package `booth_pkg`.**
  - Function `npp(W)`.
  - Enumerated type `booth_digit_t` with values ZERO, POS1, POS2, NEG1, NEG2.
  - Recoding function mapping 3 multiplier bits to `booth_digit_t`.
  - Function returning the Dadda height sequence.
- **Sub-module `dadda_reduce`.** Parametrised by row count and row width. It is purely combinational: matrix in, two rows out, built from the existing full-adder and half-adder cells.
- **Top level.** Holds the Booth encoder, the three pipeline stages, the handshake logic and the final adder.

## Test plan
- **Signed corners, no stall (W=8).**
  - Stimulus, back to back, `out_ready`=1:
    - −128·−128
    - −1·1
    - 127·−128
  - Required results, one per cycle starting 3 cycles after the first accept:
    - 0x4000
    - 0xFFFF
    - 0xC080
  - Tags are returned in order.
- **Unsigned corners (W=8).** Stimulus 0xFF·0xFF, then 0xFF·0x01, then 0x80·0x02, with `in_signed`=0. Required results: 0xFE01, 0x00FF, 0x0100.
- **Backpressure (W=16).**
  - Stimulus: hold `out_ready`=0 while streaming tags 0–5.
  - Required while stalled: `in_ready` drops after exactly 3 accepts, and `out_product`/`out_tag` stay stable.
  - Then release `out_ready`; the remaining inputs drain with no loss or duplication.
- **Mixed mode, same operands (W=16).**
  - Stimulus: 0xFFFF·0xFFFF in both modes, back to back.
  - Required results:
    - Signed: 0x0000_0001.
    - Unsigned: 0xFFFE_0001.
- **Reset mid-flight.** Stimulus: assert `rst` for 1 cycle with 3 entries in flight. Required response:
  - `out_valid`=0 and `out_product`=0 the next cycle.
  - None of the 3 in-flight results appear afterwards.
  - The first post-reset input returns its correct result 3 cycles after acceptance.
- **Random regression.** 10⁵ random operands, random mode, random `out_ready`, W ∈ {4, 8, 16, 32}. Every result matches a behavioural reference, and no tag is reordered.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the pipelined Booth/Dadda multiplier.
//   npp()           - number of radix-4 Booth digits for a W-bit operand
//   booth_digit_t   - recoded Booth digit
//   booth_recode()  - 3 multiplier bits -> Booth digit
//   dadda_h()       - j-th Dadda height (2, 3, 4, 6, 9, 13, ...)
//   dadda_nstages() - number of Dadda stages needed to bring a matrix to 2 rows
//   fa() / ha()     - full / half adder cells, result is {carry, sum}
package booth_pkg;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;

    // Operands are extended by two bits so unsigned values stay positive.
    function automatic int npp(input int w);
        return (w + 2) / 2;
    endfunction

    function automatic booth_digit_t booth_recode(input logic [2:0] b);
        case (b)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction

    function automatic int dadda_h(input int j);
        int d;
        d = 2;
        for (int i = 0; i < j; i++) d = (d * 3) / 2;
        return d;
    endfunction

    // Count of heights strictly below the initial row count.
    function automatic int dadda_nstages(input int rows);
        int n;
        n = 0;
        while (dadda_h(n) < rows) n++;
        return n;
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/dadda_reduce.sv
// dadda_reduce: combinational Dadda reduction of a bit matrix to two rows.
//   i_mat  - ROWS x COLS matrix, row r column c has weight 2^c
//   o_row0 - first output row
//   o_row1 - second output row
// Columns are treated as stacks of bits: each stage pulls bits off the
// bottom of a column into full/half adders until the column height
// (including carries arriving from the column below) meets the target.
// Bits carried beyond COLS-1 are dropped, so the sum is modulo 2^COLS.
module dadda_reduce
    import booth_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 16
) (
    input  logic [ROWS-1:0][COLS-1:0] i_mat,
    output logic [COLS-1:0]           o_row0,
    output logic [COLS-1:0]           o_row1
);

    localparam int NST = dadda_nstages(ROWS);
    // Upper bound on bits in one column pool: own bits plus incoming carries.
    localparam int PW  = 2 * ROWS + 2;

    logic [PW-1:0] w_col  [COLS];
    int            w_h    [COLS];
    logic [PW-1:0] w_nxt  [COLS];
    int            w_hn   [COLS];
    logic [PW-1:0] w_cin  [COLS+1];
    int            w_hc   [COLS+1];
    logic [PW-1:0] w_pool;
    logic [PW-1:0] w_sums;
    int            w_n;
    int            w_ns;
    int            w_d;
    logic [1:0]    w_cs;

    always_comb begin
        w_pool = '0;
        w_sums = '0;
        w_n    = 0;
        w_ns   = 0;
        w_d    = 0;
        w_cs   = '0;
        for (int c = 0; c <= COLS; c++) begin
            w_cin[c] = '0;
            w_hc[c]  = 0;
        end
        for (int c = 0; c < COLS; c++) begin
            w_col[c] = '0;
            for (int r = 0; r < ROWS; r++) w_col[c][r] = i_mat[r][c];
            w_h[c]   = ROWS;
            w_nxt[c] = '0;
            w_hn[c]  = 0;
        end

        for (int s = NST - 1; s >= 0; s--) begin
            w_d = dadda_h(s);
            for (int c = 0; c <= COLS; c++) begin
                w_cin[c] = '0;
                w_hc[c]  = 0;
            end
            for (int c = 0; c < COLS; c++) begin
                // Original bits sit below this stage's carries, so adders
                // consume original bits first.
                w_pool = w_col[c] | (w_cin[c] << w_h[c]);
                w_n    = w_h[c] + w_hc[c];
                w_sums = '0;
                w_ns   = 0;
                for (int i = 0; i < PW; i++) begin
                    if (w_n > w_d) begin
                        if (w_n == w_d + 1) begin
                            w_cs   = ha(w_pool[0], w_pool[1]);
                            w_pool = w_pool >> 2;
                            w_n    = w_n - 1;
                        end else begin
                            w_cs   = fa(w_pool[0], w_pool[1], w_pool[2]);
                            w_pool = w_pool >> 3;
                            w_n    = w_n - 2;
                        end
                        w_sums       = {w_sums[PW-2:0], w_cs[0]};
                        w_ns         = w_ns + 1;
                        w_cin[c+1]   = {w_cin[c+1][PW-2:0], w_cs[1]};
                        w_hc[c+1]    = w_hc[c+1] + 1;
                    end
                end
                // Leftover pool bits stay at the bottom, sums stack above.
                w_nxt[c] = w_pool | (w_sums << (w_n - w_ns));
                w_hn[c]  = w_n;
            end
            for (int c = 0; c < COLS; c++) begin
                w_col[c] = w_nxt[c];
                w_h[c]   = w_hn[c];
            end
        end

        for (int c = 0; c < COLS; c++) begin
            o_row0[c] = w_col[c][0];
            o_row1[c] = w_col[c][1];
        end
    end

endmodule

// File: rtl/booth_dadda_mul_pipe.sv
// booth_dadda_mul_pipe: 3-stage radix-4 Booth / Dadda multiplier.
//   clk, rst                - clock, synchronous active-high reset
//   in_valid / in_ready     - operand handshake
//   in_a, in_b, in_signed   - operands and mode (1 = two's complement)
//   in_tag                  - sideband tag, returned with the result
//   out_valid / out_ready   - result handshake
//   out_product, out_tag    - low 2W bits of a*b and its tag
// S1 registers Booth rows, S2 registers the Dadda pair, S3 registers the
// final sum. Each stage advances when it is empty or the stage after it
// advances, so bubbles collapse under backpressure.
module booth_dadda_mul_pipe
    import booth_pkg::*;
#(
    parameter int W     = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_product,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NPP  = npp(W);
    localparam int XW   = W + 2;       // extended operand width
    localparam int PPW  = W + 3;       // partial product width
    localparam int COLS = 2 * W;
    localparam int ROWS = NPP + 2;     // NPP products, negate row, constant row

    // Sign-extension prevention: each row carries ~s at column XW+2k and
    // the -2^(XW+2k) terms fold into this single constant row.
    function automatic logic [COLS-1:0] sep_const();
        logic [COLS-1:0] acc;
        acc = '0;
        for (int k = 0; k < NPP; k++) acc = acc - (COLS'(1) << (XW + 2 * k));
        return acc;
    endfunction

    localparam logic [COLS-1:0] SEP_K = sep_const();

    // ---------------- handshake ----------------
    logic [3:1] r_vld;
    logic       w_rdy1, w_rdy2, w_rdy3;
    logic       w_adv1, w_adv2, w_adv3;

    assign w_rdy3    = ~r_vld[3] | out_ready;
    assign w_rdy2    = ~r_vld[2] | w_rdy3;
    assign w_rdy1    = ~r_vld[1] | w_rdy2;
    assign in_ready  = w_rdy1;
    assign out_valid = r_vld[3];
    assign w_adv1    = in_valid & w_rdy1;
    assign w_adv2    = r_vld[1] & w_rdy2;
    assign w_adv3    = r_vld[2] & w_rdy3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (w_rdy1) r_vld[1] <= in_valid;
            if (w_rdy2) r_vld[2] <= r_vld[1];
            if (w_rdy3) r_vld[3] <= r_vld[2];
        end
    end

    // ---------------- Booth encoder ----------------
    logic [XW-1:0]           w_aext, w_bext;
    logic [NPP-1:0][PPW-1:0] w_pp;
    logic [NPP-1:0]          w_neg;

    assign w_aext = {{2{in_signed & in_a[W-1]}}, in_a};
    assign w_bext = {{2{in_signed & in_b[W-1]}}, in_b};

    for (genvar k = 0; k < NPP; k++) begin : g_pp
        logic [2:0]     w_bits;
        booth_digit_t   w_dig;
        logic [PPW-1:0] w_mag;

        if (k == 0) begin : g_lsb
            assign w_bits = {w_bext[1:0], 1'b0};
        end else begin : g_mid
            assign w_bits = w_bext[2*k+1:2*k-1];
        end

        assign w_dig = booth_recode(w_bits);

        always_comb begin
            case (w_dig)
                POS1, NEG1: w_mag = {w_aext[XW-1], w_aext};
                POS2, NEG2: w_mag = {w_aext, 1'b0};
                default:    w_mag = '0;
            endcase
        end

        // One's complement here; the +1 goes into the negate row at column 2k.
        assign w_neg[k] = (w_dig == NEG1) || (w_dig == NEG2);
        assign w_pp[k]  = w_neg[k] ? ~w_mag : w_mag;
    end

    // ---------------- S1 ----------------
    logic [NPP-1:0][PPW-1:0] r_pp;
    logic [NPP-1:0]          r_neg;
    logic [TAG_W-1:0]        r_tag1;

    // ---------------- S2: matrix build + Dadda ----------------
    logic [ROWS-1:0][COLS-1:0] w_mat;
    logic [COLS-1:0]           w_row0, w_row1;
    logic [COLS-1:0]           r_s0, r_s1;
    logic [TAG_W-1:0]          r_tag2;

    always_comb begin
        w_mat = '0;
        for (int k = 0; k < NPP; k++) begin
            w_mat[k]          = COLS'({~r_pp[k][PPW-1], r_pp[k][XW-1:0]}) << (2 * k);
            w_mat[NPP][2 * k] = r_neg[k];
        end
        w_mat[NPP+1] = SEP_K;
    end

    dadda_reduce #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_dadda (
        .i_mat  (w_mat),
        .o_row0 (w_row0),
        .o_row1 (w_row1)
    );

    always_ff @(posedge clk) begin
        if (w_adv1) begin
            r_pp   <= w_pp;
            r_neg  <= w_neg;
            r_tag1 <= in_tag;
        end
        if (w_adv2) begin
            r_s0   <= w_row0;
            r_s1   <= w_row1;
            r_tag2 <= r_tag1;
        end
    end

    // ---------------- S3: final adder ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_product <= '0;
            out_tag     <= '0;
        end else if (w_adv3) begin
            out_product <= r_s0 + r_s1;
            out_tag     <= r_tag2;
        end
    end

endmodule
